// File: rtl/motor_pkg.sv
// motor_pkg: shared steering codes, FSM state encoding and duty defaults for the motor drive path
package motor_pkg;
  localparam logic [3:0] DIR_FWD    = 4'b0000;
  localparam logic [3:0] DIR_VEER_L = 4'b0101;
  localparam logic [3:0] DIR_VEER_R = 4'b1001;
  localparam logic [3:0] DIR_STOP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_BRAKE = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DECEL = 2'd2
  } st_e;

  localparam int unsigned FULL_DUTY_DEF = 255;
  localparam int unsigned SLOW_DUTY_DEF = 96;

  typedef struct packed {
    logic       stop;
    logic [7:0] l;
    logic [7:0] r;
  } tgt_t;

  // any code other than the three driving codes is a stop request
  function automatic tgt_t dir_decode(input logic [3:0] d, input logic [7:0] full, input logic [7:0] slow);
    return d == DIR_FWD    ? {1'b0, full, full} :
           d == DIR_VEER_L ? {1'b0, slow, full} :
           d == DIR_VEER_R ? {1'b0, full, slow} : {1'b1, 16'd0};
  endfunction
endpackage

// File: rtl/pwm_ramp_chan.sv
// pwm_ramp_chan: one motor channel - slew-limited pending duty, period-aligned applied duty, PWM comparator
module pwm_ramp_chan #(
  parameter logic [8:0] STEP = 9'd32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       tick,
  input  logic       wrap,
  input  logic [7:0] target,
  input  logic [7:0] cnt,
  output logic [7:0] duty,
  output logic       pwm
);
  logic [7:0] pend, pend_nx;
  logic [8:0] up, dn;

  // move pending toward target by at most STEP, clamping exactly at target
  always_comb begin
    up = {1'b0, pend} + STEP;
    dn = {1'b0, pend} - STEP;
    pend_nx = !tick ? pend
            : target > pend ? (up >= {1'b0, target} ? target : up[7:0])
            : (dn[8] || dn[7:0] <= target) ? target : dn[7:0];
  end

  // pending follows the ramp every clk; applied duty changes only at a period wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      duty <= '0;
    end else if (clr) begin
      pend <= '0;
      duty <= '0;
    end else begin
      pend <= pend_nx;
      if (wrap) duty <= pend_nx;
    end

  assign pwm = cnt < duty;
endmodule

// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive: dual H-bridge PWM drive with period-aligned duty and brake sequencing; MOTOR_RAMP_EN enables the soft ramp
module motor_pwm_drive
  import motor_pkg::*;
#(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned FULL_DUTY = FULL_DUTY_DEF,
  parameter int unsigned SLOW_DUTY = SLOW_DUTY_DEF,
  parameter int unsigned RAMP_DIV  = 2_500_000,
  parameter int unsigned RAMP_STEP = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dir,
  output logic       ml_a,
  output logic       ml_b,
  output logic       mr_a,
  output logic       mr_b,
  output logic [7:0] duty_l,
  output logic [7:0] duty_r,
  output logic [1:0] state
);
  localparam int PW = $clog2(PRESCALE + 1);

  logic [3:0]    dir_q;
  logic [PW-1:0] presc;
  logic [7:0]    cnt;
  logic          inc, wrap, tick, brk, pwm_l, pwm_r;
  logic [7:0]    tgt_l, tgt_r;
  st_e           st, st_nx;
  tgt_t          dec;

  assign dec  = dir_decode(dir_q, 8'(FULL_DUTY), 8'(SLOW_DUTY));
  assign inc  = presc == PW'(PRESCALE - 1);
  assign wrap = inc && cnt == 8'hff;

  // steering input register and shared PWM time base
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dir_q <= DIR_STOP;
      presc <= '0;
      cnt   <= '0;
    end else begin
      dir_q <= dir;
      presc <= inc ? '0 : presc + PW'(1);
      cnt   <= cnt + 8'(inc);
    end

`ifdef MOTOR_RAMP_EN
  localparam int TW = $clog2(RAMP_DIV + 1);
  localparam logic [8:0] STEP = 9'(RAMP_STEP);
  logic [TW-1:0] tmr;
  assign tick = tmr == TW'(RAMP_DIV - 1);
  // ramp timer: one tick every RAMP_DIV clocks
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmr <= '0;
    else tmr <= tick ? '0 : tmr + TW'(1);
`else
  // a step wider than the duty range makes pending equal target on every clk
  localparam logic [8:0] STEP = 9'd256;
  logic unused_cfg;
  assign tick = 1'b1;
  assign unused_cfg = (RAMP_DIV != 0) ^ (RAMP_STEP != 0);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ST_BRAKE;
    else st <= st_nx;

  // next state from the registered steering code and the applied duties
  always_comb
    st_nx = st == ST_BRAKE ? (dec.stop ? ST_BRAKE : ST_DRIVE)
          : st == ST_DRIVE ? (dec.stop ? ST_DECEL : ST_DRIVE)
          : !dec.stop ? ST_DRIVE
          : (duty_l == 8'd0 && duty_r == 8'd0) ? ST_BRAKE : ST_DECEL;

  assign brk   = st == ST_BRAKE;
  assign tgt_l = (st == ST_DRIVE && !dec.stop) ? dec.l : 8'd0;
  assign tgt_r = (st == ST_DRIVE && !dec.stop) ? dec.r : 8'd0;
  assign state = st;

  // bridge mapping: brake drives both legs high, otherwise PWM on A with B low
  always_comb begin
    ml_a = brk | pwm_l;
    ml_b = brk;
    mr_a = brk | pwm_r;
    mr_b = brk;
  end

  pwm_ramp_chan #(.STEP(STEP)) u_left (
    .clk(clk), .rst_n(rst_n), .clr(brk), .tick(tick), .wrap(wrap),
    .target(tgt_l), .cnt(cnt), .duty(duty_l), .pwm(pwm_l)
  );

  pwm_ramp_chan #(.STEP(STEP)) u_right (
    .clk(clk), .rst_n(rst_n), .clr(brk), .tick(tick), .wrap(wrap),
    .target(tgt_r), .cnt(cnt), .duty(duty_r), .pwm(pwm_r)
  );
endmodule

// File: doc/motor_pwm_drive.md
Name: motor_pwm_drive

Overview:
- Downstream of the magnetic-sensor debounce/steering stage. Consumes its 4-bit DIR steering code and drives two H-bridge channels (left and right motor) with PWM.
- Duty changes are slew-limited (soft ramp) and applied only at PWM period boundaries.
- Sequences a controlled deceleration into active braking on a stop command.

Parameters:
- PRESCALE, 4, clk cycles per PWM counter increment; PWM period = PRESCALE*256 clk.
- FULL_DUTY, 255, duty for a motor running at full speed.
- SLOW_DUTY, 96, duty for the inner motor while veering.
- RAMP_DIV, 2_500_000, clk cycles between ramp steps (100 ms at 25 MHz).
- RAMP_STEP, 32, maximum duty change per ramp step.

Ports:
- clk  in  1  system clock, 25 MHz
- rst_n  in  1  asynchronous active-low reset
- dir  in  4  steering code from the upstream stage; level-held, same clock domain
- ml_a  out  1  left bridge input A
- ml_b  out  1  left bridge input B
- mr_a  out  1  right bridge input A
- mr_b  out  1  right bridge input B
- duty_l  out  8  applied left duty, for status/LEDs
- duty_r  out  8  applied right duty, for status/LEDs
- state  out  2  FSM state: 0 BRAKE, 1 DRIVE, 2 DECEL

Behaviour:
- Reset (async, rst_n low):
  - state = BRAKE; duty_l = duty_r = 0.
  - All bridge outputs = 1 (brake).
  - PWM counter, prescaler and ramp timer = 0.
- dir is registered once (dir_q); all decode uses dir_q, giving 1 clk input latency.
- Decode of dir_q to target duties (left, right):
  - 4'b0000: FULL, FULL
  - 4'b0101 (veer left): SLOW, FULL
  - 4'b1001 (veer right): FULL, SLOW
  - 4'b1111 and every other code: stop request
- PWM counter: 8-bit, increments when the prescaler reaches PRESCALE-1, wraps 255->0.
  - pwm_x = (cnt < duty_x). Duty 0 never pulses; duty 255 is high 255/256 of the period.
- Ramp timer: counts 0..RAMP_DIV-1 and raises a 1-clk ramp_tick on wrap.
  - On ramp_tick, each channel's pending duty moves toward its target by at most RAMP_STEP, saturating exactly at the target (no overshoot, no 8-bit wrap).
  - The arithmetic is done in 9 bits.
- Applied duty_x loads the pending duty only when cnt wraps 255->0, so there are no glitched PWM periods.
- FSM:
  - BRAKE: pending and applied duties are 0; ml_a = ml_b = mr_a = mr_b = 1. Any non-stop dir_q -> DRIVE next clk.
  - DRIVE: ml_a = pwm_l, ml_b = 0, mr_a = pwm_r, mr_b = 0. Targets follow the decode. A stop request -> DECEL.
  - DECEL: targets are 0 and the bridges keep the DRIVE mapping. When both applied duties are 0 -> BRAKE. A non-stop dir_q during DECEL -> DRIVE; the ramp continues from the current duty with no jump.
- Boundary cases:
  - A steering change in DRIVE (e.g. veer left to veer right) retargets immediately. One channel may ramp up while the other ramps down in the same tick.
  - A ramp_tick and a period wrap in the same clk: the ramp update is computed first and the wrap loads the updated value.
  - Reset mid-ramp: immediate brake; outputs are asynchronous to clk.
  - dir changing every clk: the FSM follows dir_q each clk; duties remain slew-limited.

Optional Feature:
- Macro MOTOR_RAMP_EN.
- Defined: slew-limited ramp as above.
- Undefined: no ramp timer; pending duty = target each clk, so applied duty jumps to target at the next period boundary.
- DECEL still exists in both builds. Without the ramp it lasts until the next period wrap.

Decomposition:
- Shared package (motor_pkg) holds:
  - DIR code constants (DIR_FWD, DIR_VEER_L, DIR_VEER_R, DIR_STOP), used by the upstream steering stage too.
  - State encoding constants ST_BRAKE, ST_DRIVE, ST_DECEL.
  - Default duty constants.
- One natural sub-module, pwm_ramp_chan, instantiated twice. It contains the pending/applied duty registers, the saturating step and the comparator. The counter, prescaler, ramp timer and FSM are shared in the top level.

Test Plan (PRESCALE=1, RAMP_DIV=16, RAMP_STEP=32, MOTOR_RAMP_EN defined unless stated):
- Reset, then dir=1111 held -> state=0, all bridge outputs 1, duty_l = duty_r = 0 for 2000 clk.
- dir=0000 from BRAKE -> state=1 two clk later. duty_l/duty_r step 32, 64, ... 224, 255 at period boundaries; ml_b = mr_b = 0 throughout; pwm high 255 of 256 counts at steady state.
- At steady FULL, dir=0101 -> duty_l ramps 255, 223, 191, 159, 127, 96; duty_r stays 255.
- At steady FULL, dir=1111 -> state=2; both duties ramp to 0, then state=0 and the outputs brake.
- During DECEL at duty 128, dir=1001 -> state=1; duty_l ramps up from 128 and duty_r ramps from 128 to 96, with no jump greater than 32.
- MOTOR_RAMP_EN undefined, dir=0000 -> duty 0->255 at the first period wrap. Assert rst_n low mid-period -> bridge outputs 1 within the same clk, before the next clk edge.
